// File: rtl/tr_pkg.sv
// Shared types and defaults for the step pulse monitor: FSM states, default widths and
// synchronizer depth.
package tr_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StMeasure,
      StStall
   } tr_state_e;

   localparam int unsigned TR_SIZE       = 16;
   localparam int unsigned TR_N          = 100;
   localparam int unsigned TR_POS_W      = 32;
   localparam int unsigned TR_SYNC_DEPTH = 2;

endpackage

// File: rtl/step_sync_edge.sv
// Brings step/dir into the clk domain and produces a one-cycle registered rising-edge strobe
// with the direction sampled through an equally long pipeline.
module step_sync_edge
   import tr_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic step_in,
   input  logic dir_in,
   output logic step_edge,
   output logic dir
);

   logic [TR_SYNC_DEPTH-1:0] step_sync;
   logic [TR_SYNC_DEPTH-1:0] dir_sync;
   logic                     step_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_sync <= '0;
         dir_sync  <= '0;
         step_last <= 1'b0;
         step_edge <= 1'b0;
         dir       <= 1'b0;
      end else begin
         step_sync <= {step_sync[TR_SYNC_DEPTH-2:0], step_in};
         dir_sync  <= {dir_sync[TR_SYNC_DEPTH-2:0], dir_in};
         step_last <= step_sync[TR_SYNC_DEPTH-1];
         step_edge <= step_sync[TR_SYNC_DEPTH-1] & ~step_last;
         // dir takes its third stage here so it lines up with step_edge
         dir       <= dir_sync[TR_SYNC_DEPTH-1];
      end
   end

endmodule

// File: rtl/step_pulse_monitor.sv
// Step/direction receiver: measures edge-to-edge period, tracks signed position, counts pulses
// toward a move length and flags a stall when pulses stop.
module step_pulse_monitor
   import tr_pkg::*;
#(
   parameter int unsigned SIZE  = TR_SIZE,
   parameter int unsigned N     = TR_N,
   parameter int unsigned POS_W = TR_POS_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step_in,
   input  logic             dir_in,
   input  logic             en,
   input  logic             clr,
   output logic [SIZE-1:0]  period,
   output logic             period_valid,
   output logic [POS_W-1:0] position,
   output logic             move_done,
   output logic             stall
);

   localparam int unsigned     CW      = $clog2(N + 1);
   localparam logic [SIZE-1:0] CntMax  = {SIZE{1'b1}};
   localparam logic [CW-1:0]   CntDone = CW'(N);

   logic             step_edge;
   logic             dir;
   tr_state_e        state;
   logic [SIZE-1:0]  cnt;
   logic [CW-1:0]    pulses;
   logic [CW-1:0]    pulses_next;
   logic [POS_W-1:0] pos_next;

   step_sync_edge u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .step_in   (step_in),
      .dir_in    (dir_in),
      .step_edge (step_edge),
      .dir       (dir)
   );

   always_comb begin
      pos_next    = dir ? position + POS_W'(1) : position - POS_W'(1);
      pulses_next = (pulses == CntDone) ? pulses : pulses + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= StIdle;
         cnt          <= '0;
         pulses       <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         position     <= '0;
         move_done    <= 1'b0;
         stall        <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         // clr and en-low both discard any coincident edge
         if (clr) begin
            position  <= '0;
            pulses    <= '0;
            move_done <= 1'b0;
            stall     <= 1'b0;
            state     <= en ? StArm : StIdle;
         end else if (!en) begin
            stall <= 1'b0;
            state <= StIdle;
         end else begin
            if (step_edge && state != StIdle) begin
               position  <= pos_next;
               pulses    <= pulses_next;
               move_done <= move_done | (pulses_next == CntDone);
            end
            unique case (state)
               StIdle: state <= StArm;
               StArm: begin
                  if (step_edge) begin
                     cnt   <= SIZE'(1);
                     state <= StMeasure;
                  end
               end
               StMeasure: begin
                  if (step_edge) begin
                     period       <= cnt;
                     period_valid <= 1'b1;
                     cnt          <= SIZE'(1);
                  end else if (cnt == CntMax) begin
                     stall <= 1'b1;
                     state <= StStall;
                  end else begin
                     cnt <= cnt + SIZE'(1);
                  end
               end
               StStall: begin
                  // interval spanned a stall, so it is not reported
                  if (step_edge) begin
                     cnt   <= SIZE'(1);
                     stall <= 1'b0;
                     state <= StMeasure;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_step_pulse_monitor.sv
// Self-checking bench for step_pulse_monitor; expected periods are queued as pulses are driven
// and checked against each period_valid strobe.
module tb_step_pulse_monitor;

   localparam int unsigned SIZE  = 8;
   localparam int unsigned N     = 100;
   localparam int unsigned POS_W = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             step_in;
   logic             dir_in;
   logic             en;
   logic             clr;
   logic [SIZE-1:0]  period;
   logic             period_valid;
   logic [POS_W-1:0] position;
   logic             move_done;
   logic             stall;

   int               n_tests = 0;
   int               n_fail = 0;
   int               n_valid = 0;
   int               sb_exp;
   int               exp_periods[$];
   int               last_len = 0;
   bit               meas = 1'b0;
   logic [POS_W-1:0] exp_pos = '0;

   always #5 clk = ~clk;

   step_pulse_monitor #(
      .SIZE  (SIZE),
      .N     (N),
      .POS_W (POS_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .step_in      (step_in),
      .dir_in       (dir_in),
      .en           (en),
      .clr          (clr),
      .period       (period),
      .period_valid (period_valid),
      .position     (position),
      .move_done    (move_done),
      .stall        (stall)
   );

   always @(negedge clk) begin
      if (rst_n === 1'b1 && period_valid === 1'b1) begin
         n_tests++;
         n_valid++;
         if (exp_periods.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_period_valid: period=%0d, required no strobe", period);
         end else begin
            sb_exp = exp_periods.pop_front();
            if (period !== sb_exp[SIZE-1:0]) begin
               n_fail++;
               $display("FAIL period_value: got %0d, required %0d", period, sb_exp);
            end
         end
      end
   end

   task automatic pulse(input int high, input int low, input bit d);
      dir_in = d;
      @(posedge clk); #1 step_in = 1'b1;
      if (meas) exp_periods.push_back(last_len);
      exp_pos = d ? exp_pos + 1 : exp_pos - 1;
      repeat (high) begin @(posedge clk); #1; end
      step_in = 1'b0;
      repeat (low - 1) begin @(posedge clk); #1; end
      meas     = 1'b1;
      last_len = high + low;
   endtask

   // Raises clr or drops en in exactly the cycle the edge strobe is high.
   task automatic pulse_with_event(input bit use_clr);
      dir_in = 1'b1;
      @(posedge clk); #1 step_in = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      if (use_clr) clr = 1'b1;
      else en = 1'b0;
      @(posedge clk); #1 clr = 1'b0;
      repeat (46) begin @(posedge clk); #1; end
      step_in = 1'b0;
      repeat (149) begin @(posedge clk); #1; end
      meas = 1'b0;
      if (use_clr) exp_pos = '0;
   endtask

   task automatic do_clr();
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      meas    = 1'b0;
      exp_pos = '0;
   endtask

   task automatic check_pos(input string name);
      @(negedge clk);
      n_tests++;
      if (position !== exp_pos) begin
         n_fail++;
         $display("FAIL %s: position=%0d, required %0d", name, $signed(position),
                  $signed(exp_pos));
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; step_in = 1'b0; dir_in = 1'b0; en = 1'b0; clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({period, period_valid, position, move_done, stall} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: period=%0d valid=%b position=%0d done=%b stall=%b, required 0",
                  period, period_valid, position, move_done, stall);
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int v0;
      en = 1'b1;
      v0 = n_valid;
      for (int i = 0; i < 5; i++) pulse(50, 150, 1'b1);
      check_pos("basic_position");
      n_tests++;
      if (n_valid - v0 != 4) begin
         n_fail++;
         $display("FAIL basic_valid_count: got %0d strobes, required 4", n_valid - v0);
      end
   endtask

   task automatic test_direction();
      for (int i = 0; i < 3; i++) pulse(50, 150, 1'b0);
      check_pos("reverse_position");
      pulse(50, 150, 1'b1);
      check_pos("dir_toggle_position");
   endtask

   task automatic test_move_done();
      int lat = 0;
      do_clr();
      check_pos("clr_position");
      for (int i = 0; i < 99; i++) pulse(50, 51, 1'b1);
      @(negedge clk);
      n_tests++;
      if (move_done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_early: move_done=%b after 99 pulses, required 0", move_done);
      end
      dir_in = 1'b1;
      @(posedge clk); #1 step_in = 1'b1;
      exp_periods.push_back(last_len);
      exp_pos = exp_pos + 1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (lat == 0 && move_done === 1'b1) lat = i;
      end
      n_tests++;
      if (lat != 4) begin
         n_fail++;
         $display("FAIL done_latency: move_done after %0d clocks, required 4", lat);
      end
      repeat (40) begin @(posedge clk); #1; end
      step_in = 1'b0;
      repeat (50) begin @(posedge clk); #1; end
      pulse(50, 51, 1'b1);
      @(negedge clk);
      n_tests++;
      if (move_done !== 1'b1 || position !== exp_pos) begin
         n_fail++;
         $display("FAIL done_sticky: move_done=%b position=%0d, required 1 and %0d", move_done,
                  position, exp_pos);
      end
      do_clr();
      @(negedge clk);
      n_tests++;
      if (move_done !== 1'b0 || position !== '0) begin
         n_fail++;
         $display("FAIL done_clear: move_done=%b position=%0d, required 0 and 0", move_done,
                  position);
      end
   endtask

   task automatic test_stall();
      int  n = 0;
      bit  found = 1'b0;
      bit  stalled = 1'b0;
      dir_in = 1'b1;
      @(posedge clk); #1 step_in = 1'b1;
      exp_pos = exp_pos + 1;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk); #1;
         if (position === exp_pos) found = 1'b1;
      end
      while (n < 400 && !stalled) begin
         @(posedge clk); #1;
         n++;
         if (n == 45) step_in = 1'b0;
         if (stall === 1'b1) stalled = 1'b1;
      end
      n_tests++;
      if (!found || n != 255) begin
         n_fail++;
         $display("FAIL stall_timing: edge_seen=%b stall after %0d cycles, required 1 and 255",
                  found, n);
      end
      step_in = 1'b0;
      meas    = 1'b0;
      pulse(50, 150, 1'b1);
      @(negedge clk);
      n_tests++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_clear: stall=%b, required 0", stall);
      end
      pulse(50, 150, 1'b1);
      check_pos("after_stall_position");
   endtask

   task automatic test_clr_edge();
      pulse_with_event(1'b1);
      check_pos("clr_edge_position");
      pulse(50, 150, 1'b1);
      check_pos("clr_rearm_position");
   endtask

   task automatic test_en_drop();
      pulse(50, 150, 1'b1);
      pulse_with_event(1'b0);
      check_pos("en_drop_position");
      n_tests++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL en_drop_stall: stall=%b, required 0", stall);
      end
      @(posedge clk); #1 en = 1'b1;
      pulse(50, 150, 1'b1);
      pulse(50, 150, 1'b1);
      check_pos("reenable_position");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({period, period_valid, position, move_done, stall} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: period=%0d position=%0d done=%b stall=%b, required 0",
                  period, position, move_done, stall);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_pos = '0;
      meas    = 1'b0;
   endtask

   task automatic test_glitch();
      @(posedge clk); #1 step_in = 1'b1;
      @(posedge clk); #1 step_in = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      @(negedge clk);
      n_tests++;
      if (^{period, period_valid, position, move_done, stall} === 1'bx) begin
         n_fail++;
         $display("FAIL glitch_no_x: outputs=%b, required no X",
                  {period, period_valid, position, move_done, stall});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_direction();
      test_move_done();
      test_stall();
      test_clr_edge();
      test_en_drop();
      test_reset_mid();
      test_glitch();
      n_tests++;
      if (exp_periods.size() != 0) begin
         n_fail++;
         $display("FAIL missing_period_valid: %0d strobes outstanding, required 0",
                  exp_periods.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/step_pulse_monitor.md
# step_pulse_monitor

Receive-side counterpart to the stepper-motor step generator. Takes the step/direction pair as it appears at the driver input and re-synchronises it into `clk`. Measures the clock-cycle period between consecutive step pulses, accumulates signed motor position and counts pulses toward the hand-mode move length. Flags a stall when pulses stop. Used for closed-loop checking of the generator and for position readback to the control logic.

## Interface
- `SIZE`, 16, width of the period measurement, saturating.
- `N`, 100, pulse count that completes a hand-mode move.
- `POS_W`, 32, width of the signed position accumulator.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `step_in`  in  1  step pulse, asynchronous to `clk`; rising edge = one step.
- `dir_in`  in  1  direction, asynchronous; 1 = forward (+1), 0 = reverse (−1).
- `en`  in  1  monitor enable.
- `clr`  in  1  synchronous clear of position, pulse count and done flag.
- `period`  out  SIZE  last measured edge-to-edge period in `clk` cycles.
- `period_valid`  out  1  one-cycle strobe when `period` updates.
- `position`  out  POS_W  signed step position, two's complement.
- `move_done`  out  1  sticky; set when pulse count reaches `N`.
- `stall`  out  1  no step edge within 2^SIZE−1 cycles while measuring.

## Operation
- Input path: `step_in` and `dir_in` each pass through a 2-FF synchronizer. A registered copy of synchronized step yields `edge` = rising edge, one cycle wide. `dir` is sampled with the same pipeline, so it stays aligned with `edge`.
- States: IDLE, ARM, MEASURE, STALL.
  - IDLE: `en`=0; all counters hold.
  - `en` rising → ARM.
  - ARM: first `edge` updates position and count and starts the period counter; no `period_valid`; → MEASURE.
  - MEASURE: on `edge`, `period` ← cycle count since the previous edge, `period_valid`=1, period counter restarts.
  - MEASURE: period counter reaching 2^SIZE−1 → STALL, `stall`=1.
  - STALL: next `edge` → MEASURE, `stall`=0, period counter restarts; no `period_valid` (measurement invalid).
  - `en`=0 from any state → IDLE. `stall` clears; `period`, `position` and count hold.
- Period counter: set to 1 on the edge cycle and increments each cycle. Edges detected at cycles t0 and t1 give `period` = t1−t0. It saturates and never wraps.
- Position: every accepted `edge` adds +1 if `dir`=1 and −1 if `dir`=0. It wraps modulo 2^POS_W.
- Pulse count: increments on every accepted `edge` and saturates at `N`. `move_done` is set in the cycle the count becomes `N` and stays set until `clr` or reset.
- `clr`: `position`=0, count=0, `move_done`=0, `stall`=0. Next state is ARM if `en`=1, else IDLE. `period` holds.
- Simultaneous events:
  - `clr` and `edge` in the same cycle: `clr` wins and the edge is discarded.
  - `en` falling and `edge` in the same cycle: the edge is discarded.
- Edges are accepted only in ARM, MEASURE and STALL.

## Timing
- Reset values: `period`=0, `period_valid`=0, `position`=0, `move_done`=0, `stall`=0, state IDLE, synchronizers 0.
- Latency:
  - `step_in` rising edge to `edge`: 3 `clk` cycles (2 sync + 1 edge register).
  - `edge` to `period`/`period_valid`/`position`/`move_done`: registered, visible the cycle after `edge`.
  - Total pin-to-output latency: 4 cycles.
- Minimum resolvable step: high ≥ 2 cycles and low ≥ 2 cycles. Shorter pulses may be lost; no error is flagged.
- `dir_in` must be stable ≥ 1 cycle before the `step_in` rise. It is sampled through the same 3-cycle pipeline.
- `stall` asserts the cycle after the counter reaches 2^SIZE−1.
- `rst_n` low mid-operation clears everything immediately (asynchronous). Release must be synchronous to `clk`, which is handled externally.

## Structure
- Shared package `tr_pkg`:
  - state enum (IDLE/ARM/MEASURE/STALL);
  - default constants `TR_SIZE`=16, `TR_N`=100, `TR_POS_W`=32;
  - synchronizer depth constant = 2.
- One sub-module, `step_sync_edge`: 2-FF synchronizer for step and dir plus the rising-edge detector. Outputs are `edge` and `dir`.
- Top: FSM, period counter, position accumulator, pulse counter.

## Test plan
- Reset then `en`=1; step period 200 cycles (high 50), `dir_in`=1, 5 pulses → no valid on the 1st edge; 4 `period_valid` strobes with `period`=200; `position`=5.
- `dir_in`=0, 3 pulses after the above → `position`=2; toggle `dir` 1 cycle before a rise → that step counts with the new direction.
- 100 pulses at period 101 with `N`=100 → `move_done` rises the cycle after the 100th `edge`; the 101st pulse keeps it at 1; `clr` → `move_done`=0, `position`=0.
- Stop pulses with `SIZE`=8 → `stall`=1 after 255 cycles from the last edge; next pulse → `stall`=0, no `period_valid`; following pulse → valid period.
- `clr` coincident with an `edge`; `en` deasserted mid-train → edge discarded, `position` holds; re-enable → ARM, first edge gives no valid.
- `rst_n` pulsed low between edges → all outputs 0 immediately; 1-cycle-wide `step_in` glitch → no count change required, no X on outputs.
